op_mode_commit_display: RTL
===========================

# op_mode_commit_display

Consumer-side endpoint of the operation-selection interface. Takes the debounced `op_mode`/`calc_type` pair from the switch front end and commits it to the datapath only while the compute core is idle, holding a pending request otherwise. Drives a 4-digit multiplexed seven-segment display showing the mnemonic of the pending or committed operation. Sits between the mode controller and the matrix core's operation selector, alongside the board I/O.

## Interface
- `SCAN_DIV`, 25000: clocks per digit slot (1 ms at 25 MHz).
- `BLINK_DIV`, 6250000: clocks per blink half-period (250 ms at 25 MHz); used only with blink compiled in.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `op_mode` in 3: requested mode (`op_mode_t`, `matrix_op_selector_pkg`).
- `calc_type` in 3: requested calculation (`calc_type_t`).
- `core_busy` in 1: core executing; mode must not change while high.
- `committed_op_mode` out 3: mode presented to the core.
- `committed_calc_type` out 3: calculation presented to the core.
- `mode_changed` out 1: one-cycle pulse, high in the first cycle a new committed value is valid.
- `pending` out 1: requested pair differs from committed pair and is awaiting commit.
- `seg` out 8: segments, active-high; bit0=a … bit6=g, bit7=dp.
- `an` out 4: digit enables, active-high, one-hot; `an[3]` leftmost.

## Operation
- Commit FSM, states IDLE and PENDING:
  - IDLE, request == committed: stay.
  - IDLE, request != committed, `core_busy`=0: commit at this edge, stay IDLE.
  - IDLE, request != committed, `core_busy`=1: go PENDING.
  - PENDING, request == committed (user reverted): go IDLE, no commit, no pulse.
  - PENDING, `core_busy`=0, request != committed: commit the current request (latest value, not the value that entered PENDING) and go IDLE.
- `pending` = (state==PENDING), registered.
- Committed values are copied verbatim; no legality check.
- Display source: request pair while PENDING, else committed pair.
- Mnemonics (digit3..digit0, blank=0x00): TRANSPOSE "tr  ", ADD "Add ", MUL "nnuL", SCALAR_MUL "SnnL", CONV "Conu". Any other `calc_type` code: "----" (0x40 each).
- Glyphs: t=0x78, r=0x50, A=0x77, d=0x5E, n=0x54, u=0x1C, L=0x38, S=0x6D, C=0x39, o=0x5C.
- Scan: prescaler counts 0..SCAN_DIV-1; on wrap, digit index steps 3→2→1→0→3. `an` = one-hot of index; `seg` = glyph of that digit. Both registered.

## Timing
- Reset values: committed = OP_SINGLE/CALC_TRANSPOSE, state IDLE, `pending`=0, `mode_changed`=0, prescaler 0, blink counter 0, digit index 3, `an`=4'b1000, `seg`=0x78.
- Commit latency: committed outputs update at the first edge where mismatch and `core_busy`=0 are both sampled; `mode_changed` is high for exactly the following cycle.
- Request change and `core_busy` rising in the same cycle: busy wins, go PENDING.
- `core_busy` falling with request change in same cycle: commit that cycle's request.
- Display refresh lags source change by at most one digit slot; `seg`/`an` change together on the same edge.
- `rst` mid-PENDING: pending request discarded, committed returns to reset values, no pulse.

## Configuration
- `OP_MODE_DISP_BLINK_EN` defined: blink counter runs modulo BLINK_DIV, toggling phase on wrap; while PENDING, `seg` forced to 0x00 in the off phase; steady when IDLE. Blink counter and phase reset on entry to IDLE.
- Undefined: no blink logic; while PENDING, dp (bit7) of digit 0 is lit, glyphs otherwise steady.

## Test plan
- Reset, SCAN_DIV=4: `an`=1000, `seg`=0x78; after 4 clocks `an`=0100, `seg`=0x50; digit0 blank.
- Idle, request OP_DOUBLE/CALC_ADD -> committed updates one edge later, `mode_changed` single pulse, digit3 `seg`=0x77.
- `core_busy`=1, request MUL -> `pending`=1, committed unchanged; change request to CONV, drop busy -> commits CONV, one pulse.
- `core_busy`=1, request ADD then back to TRANSPOSE -> `pending` returns 0, no `mode_changed`.
- `rst` asserted while PENDING -> all outputs at reset values next cycle.
- With `OP_MODE_DISP_BLINK_EN`, BLINK_DIV=8, PENDING -> `seg`=0x00 for 8-clock windows alternating with glyphs; without macro, digit0 `seg`=0x80.

Source files
------------

// File: rtl/op_mode_commit_display.sv
// op_mode_commit_display
//   Commits the requested op_mode/calc_type pair to the compute core only while
//   the core is idle. A request that arrives while the core is busy is held as
//   PENDING. Also drives a 4-digit multiplexed seven-segment display with the
//   mnemonic of the pending (if any) or committed calculation.
//
//   Optional feature macro: OP_MODE_DISP_BLINK_EN
//     defined   : the display blinks (all segments off in the off phase) while
//                 PENDING
//     undefined : no blink logic; the dp of digit 0 is lit while PENDING
//
//   Encodings follow matrix_op_selector_pkg:
//     op_mode   : OP_SINGLE=0 (other codes are passed through untouched)
//     calc_type : TRANSPOSE=0, ADD=1, MUL=2, SCALAR_MUL=3, CONV=4
//
//   Handshake: there is no valid/ready pair. The request is level-sampled every
//   cycle. A new committed value is valid from the cycle in which mode_changed
//   is high, and it stays stable until the next such pulse.
module op_mode_commit_display #(
  parameter int SCAN_DIV  = 25000,
  parameter int BLINK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op_mode,
  input  logic [2:0] calc_type,
  input  logic       core_busy,
  output logic [2:0] committed_op_mode,
  output logic [2:0] committed_calc_type,
  output logic       mode_changed,
  output logic       pending,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [2:0] OP_SINGLE       = 3'd0;
  localparam logic [2:0] CALC_TRANSPOSE  = 3'd0;
  localparam logic [2:0] CALC_ADD        = 3'd1;
  localparam logic [2:0] CALC_MUL        = 3'd2;
  localparam logic [2:0] CALC_SCALAR_MUL = 3'd3;
  localparam logic [2:0] CALC_CONV       = 3'd4;

  localparam logic [7:0] G_BLANK = 8'h00;
  localparam logic [7:0] G_DASH  = 8'h40;
  localparam logic [7:0] G_T     = 8'h78;
  localparam logic [7:0] G_R     = 8'h50;
  localparam logic [7:0] G_A     = 8'h77;
  localparam logic [7:0] G_D     = 8'h5E;
  localparam logic [7:0] G_N     = 8'h54;
  localparam logic [7:0] G_U     = 8'h1C;
  localparam logic [7:0] G_L     = 8'h38;
  localparam logic [7:0] G_S     = 8'h6D;
  localparam logic [7:0] G_C     = 8'h39;
  localparam logic [7:0] G_O     = 8'h5C;

  localparam int SCAN_W = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state_q;
  logic [2:0]  cm_op_q;
  logic [2:0]  cm_calc_q;
  logic        mode_changed_q;
  logic        pending_q;

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [1:0]        digit_idx_q;
  logic [1:0]        digit_idx_d;
  logic [3:0]        an_q;
  logic [3:0]        an_d;
  logic [7:0]        seg_q;
  logic [7:0]        seg_d;
  logic [2:0]        disp_calc;
  logic              mismatch;
  logic              scan_wrap;

  assign mismatch  = (op_mode != cm_op_q) || (calc_type != cm_calc_q);
  assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign disp_calc = pending_q ? calc_type : cm_calc_q;

  // Glyph for one digit position of a calculation mnemonic; digit 3 is leftmost.
  function automatic logic [7:0] glyph(input logic [2:0] calc, input logic [1:0] idx);
    logic [7:0] g;
    g = G_DASH;
    case (calc)
      CALC_TRANSPOSE: begin
        case (idx)
          2'd3:    g = G_T;
          2'd2:    g = G_R;
          default: g = G_BLANK;
        endcase
      end
      CALC_ADD: begin
        case (idx)
          2'd3:    g = G_A;
          2'd2:    g = G_D;
          2'd1:    g = G_D;
          default: g = G_BLANK;
        endcase
      end
      CALC_MUL: begin
        case (idx)
          2'd3:    g = G_N;
          2'd2:    g = G_N;
          2'd1:    g = G_U;
          default: g = G_L;
        endcase
      end
      CALC_SCALAR_MUL: begin
        case (idx)
          2'd3:    g = G_S;
          2'd2:    g = G_N;
          2'd1:    g = G_N;
          default: g = G_L;
        endcase
      end
      CALC_CONV: begin
        case (idx)
          2'd3:    g = G_C;
          2'd2:    g = G_O;
          2'd1:    g = G_N;
          default: g = G_U;
        endcase
      end
      default: g = G_DASH;
    endcase
    return g;
  endfunction

  // Commit FSM: a commit happens only at an edge where the core is idle. While
  // PENDING, the latest request is committed, not the one that caused the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cm_op_q        <= OP_SINGLE;
      cm_calc_q      <= CALC_TRANSPOSE;
      mode_changed_q <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      mode_changed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mismatch) begin
            if (core_busy) begin
              state_q   <= PENDING;
              pending_q <= 1'b1;
            end else begin
              cm_op_q        <= op_mode;
              cm_calc_q      <= calc_type;
              mode_changed_q <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (!mismatch) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
          end else if (!core_busy) begin
            cm_op_q        <= op_mode;
            cm_calc_q      <= calc_type;
            mode_changed_q <= 1'b1;
            state_q        <= IDLE;
            pending_q      <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef OP_MODE_DISP_BLINK_EN
  localparam int BLINK_W = ($clog2(BLINK_DIV) > 0) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;

  // Blink timebase runs only while PENDING and restarts on every return to IDLE.
  always_ff @(posedge clk) begin
    if (rst || (state_q != PENDING)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end
`endif

  // Next digit slot and its segment pattern, computed every cycle so that the
  // pending marker or blink reacts within one clock.
  always_comb begin
    digit_idx_d = scan_wrap ? (digit_idx_q - 2'd1) : digit_idx_q;
    an_d        = 4'b0001 << digit_idx_d;
    seg_d       = glyph(disp_calc, digit_idx_d);
`ifdef OP_MODE_DISP_BLINK_EN
    if (pending_q && blink_phase_q) begin
      seg_d = G_BLANK;
    end
`else
    if (pending_q && (digit_idx_d == 2'd0)) begin
      seg_d[7] = 1'b1;
    end
`endif
  end

  // Scan prescaler, digit index and registered an/seg, updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd3;
      an_q        <= 4'b1000;
      seg_q       <= G_T;
    end else begin
      scan_cnt_q  <= scan_wrap ? '0 : (scan_cnt_q + 1'b1);
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign committed_op_mode   = cm_op_q;
  assign committed_calc_type = cm_calc_q;
  assign mode_changed        = mode_changed_q;
  assign pending             = pending_q;
  assign seg                 = seg_q;
  assign an                  = an_q;

endmodule
